// File: rtl/mix_select_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mix_select_pkg
// Purpose  : Shared FSM encoding, default widths and lane offset helper for
//            the mix_select_seq word-select-and-mix engine.
// Revision : 1.0
// ============================================================================
package mix_select_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int C_STATE_WIDTH = 320;
    localparam int C_SRC_WIDTH   = 128;
    localparam int C_WORD_WIDTH  = 32;
    localparam int C_LANES       = 5;
    localparam int C_LANE_STRIDE = 2;

    // Bit offset of lane j inside the cipher state.
    function automatic int lane_base(input int lane, input int stride, input int word_width);
        return lane * stride * word_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mix_select_seq_word_pick.sv
`default_nettype none
// ============================================================================
// Module   : word_pick
// Purpose  : Combinational extraction of one WORD_WIDTH word from a source
//            block, addressed by a word index.
// Revision : 1.0
// ============================================================================
module word_pick #(
    parameter int SRC_WIDTH  = 128,
    parameter int WORD_WIDTH = 32,
    parameter int IDX_W      = 2
) (
    input  logic [SRC_WIDTH-1:0]  src,
    input  logic [IDX_W-1:0]      idx,
    output logic [WORD_WIDTH-1:0] word
);

    localparam int N_WORDS = SRC_WIDTH / WORD_WIDTH;

    logic [WORD_WIDTH-1:0] w_words [N_WORDS];

    genvar gi;
    generate
        for (gi = 0; gi < N_WORDS; gi++) begin : g_word
            assign w_words[gi] = src[gi*WORD_WIDTH +: WORD_WIDTH];
        end
    endgenerate

    assign word = w_words[idx];

endmodule
`default_nettype wire

// File: rtl/mix_select_seq.sv
`default_nettype none
// ============================================================================
// Module   : mix_select_seq
// Purpose  : XORs selector-indexed source words into strided state lanes,
//            one lane per cycle, or all lanes at once when
//            MIX_SEL_PARALLEL_EN is defined.
// Revision : 1.0
// ============================================================================
module mix_select_seq
    import mix_select_pkg::*;
#(
    parameter int STATE_WIDTH = C_STATE_WIDTH,
    parameter int SRC_WIDTH   = C_SRC_WIDTH,
    parameter int WORD_WIDTH  = C_WORD_WIDTH,
    parameter int LANES       = C_LANES,
    parameter int LANE_STRIDE = C_LANE_STRIDE,
    parameter int IDX_W       = $clog2(SRC_WIDTH / WORD_WIDTH),
    parameter int LANE_W      = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic [STATE_WIDTH-1:0]   state_in,
    input  logic [SRC_WIDTH-1:0]     src_in,
    input  logic [LANES*IDX_W-1:0]   sel,
    output logic                     done_valid,
    input  logic                     done_ready,
    output logic [STATE_WIDTH-1:0]   state_out,
    output logic                     busy
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [STATE_WIDTH-1:0]  r_work;
    logic [SRC_WIDTH-1:0]    r_src;
    logic [LANES*IDX_W-1:0]  r_sel;
    logic [STATE_WIDTH-1:0]  w_mixed;
    logic [IDX_W-1:0]        w_sel_arr [LANES];
    logic                    w_accept;
    logic                    w_last;

    assign w_accept = (r_state == IDLE) && start_valid;

    genvar gj;
    generate
        for (gj = 0; gj < LANES; gj++) begin : g_sel
            assign w_sel_arr[gj] = r_sel[gj*IDX_W +: IDX_W];
        end
    endgenerate

`ifdef MIX_SEL_PARALLEL_EN
    logic [WORD_WIDTH-1:0] w_words [LANES];

    generate
        for (gj = 0; gj < LANES; gj++) begin : g_pick
            word_pick #(
                .SRC_WIDTH  (SRC_WIDTH),
                .WORD_WIDTH (WORD_WIDTH),
                .IDX_W      (IDX_W)
            ) u_word_pick (
                .src  (r_src),
                .idx  (w_sel_arr[gj]),
                .word (w_words[gj])
            );
        end
    endgenerate

    assign w_last = 1'b1;

    always_comb begin
        w_mixed = r_work;
        for (int j = 0; j < LANES; j++) begin
            w_mixed[lane_base(j, LANE_STRIDE, WORD_WIDTH) +: WORD_WIDTH] ^= w_words[j];
        end
    end
`else
    localparam logic [LANE_W-1:0] c_last_lane = LANE_W'(LANES - 1);

    logic [LANE_W-1:0]     r_lane;
    logic [WORD_WIDTH-1:0] w_word;

    word_pick #(
        .SRC_WIDTH  (SRC_WIDTH),
        .WORD_WIDTH (WORD_WIDTH),
        .IDX_W      (IDX_W)
    ) u_word_pick (
        .src  (r_src),
        .idx  (w_sel_arr[r_lane]),
        .word (w_word)
    );

    assign w_last = (r_lane == c_last_lane);

    // Lane offsets stay constant per loop iteration; r_lane only gates which one updates.
    always_comb begin
        w_mixed = r_work;
        for (int j = 0; j < LANES; j++) begin
            if (r_lane == LANE_W'(j)) begin
                w_mixed[lane_base(j, LANE_STRIDE, WORD_WIDTH) +: WORD_WIDTH] ^= w_word;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lane <= '0;
        end else if (w_accept) begin
            r_lane <= '0;
        end else if (r_state == RUN) begin
            r_lane <= r_lane + LANE_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start_valid) w_state_nxt = RUN;
            RUN:     if (w_last)      w_state_nxt = DONE;
            DONE:    if (done_ready)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_work <= '0;
            r_src  <= '0;
            r_sel  <= '0;
        end else if (w_accept) begin
            r_work <= state_in;
            r_src  <= src_in;
            r_sel  <= sel;
        end else if (r_state == RUN) begin
            r_work <= w_mixed;
        end
    end

    assign start_ready = (r_state == IDLE);
    assign busy        = (r_state == RUN);
    assign done_valid  = (r_state == DONE);
    assign state_out   = r_work;

endmodule
`default_nettype wire

// File: tb/tb_mix_select_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mix_select_seq
// Purpose  : Directed scoreboard bench for mix_select_seq (serial build, or
//            parallel build when MIX_SEL_PARALLEL_EN is defined).
// Revision : 1.0
// ============================================================================
module tb_mix_select_seq;

    localparam int SW = 320;
    localparam int XW = 128;
`ifdef MIX_SEL_PARALLEL_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 5;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic [SW-1:0] state_in = '0;
    logic [XW-1:0] src_in = '0;
    logic [9:0]    sel = '0;
    logic          done_valid;
    logic          done_ready = 1'b0;
    logic [SW-1:0] state_out;
    logic          busy;

    int checks = 0;
    int errors = 0;
    logic [SW-1:0] sb [$];

    localparam logic [XW-1:0] SRC_A = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

    mix_select_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .state_in    (state_in),
        .src_in      (src_in),
        .sel         (sel),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .state_out   (state_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [SW-1:0] mix_model(input logic [SW-1:0] s, input logic [XW-1:0] x,
                                                input logic [9:0] sl);
        logic [SW-1:0] r;
        logic [1:0]    idx;
        r = s;
        for (int j = 0; j < 5; j++) begin
            idx = sl[j*2 +: 2];
            r[j*64 +: 32] = r[j*64 +: 32] ^ x[int'(idx)*32 +: 32];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [SW-1:0] s, input logic [XW-1:0] x, input logic [9:0] sl);
        int n;
        n = 0;
        while (!start_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("start_ready_before_accept", SW'(start_ready), SW'(1));
        state_in = s; src_in = x; sel = sl; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        sb.push_back(mix_model(s, x, sl));
    endtask

    // Waits for done_valid, optionally scrambling inputs that must be ignored.
    task automatic wait_done(input bit scramble);
        int lat;
        lat = 0;
        while (!done_valid && lat < 50) begin
            if (scramble) begin
                state_in = {10{$urandom()}}; src_in = {4{$urandom()}}; sel = 10'($urandom());
            end
            @(posedge clk); #1; lat++;
        end
        check("latency", SW'(lat), SW'(LAT));
    endtask

    task automatic finish_op(input string tag);
        logic [SW-1:0] exp;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s_scoreboard_empty observed=0 expected=1", tag);
        end
        exp = (sb.size() > 0) ? sb.pop_front() : '0;
        check(tag, state_out, exp);
        done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
        check("done_valid_falls", SW'(done_valid), SW'(0));
        check("start_ready_after_done", SW'(start_ready), SW'(1));
    endtask

    initial begin
        logic [SW-1:0] held;
        logic [SW-1:0] rs;
        logic [XW-1:0] rx;
        logic [9:0]    rl;

        #12;
        check("reset_start_ready", SW'(start_ready), SW'(1));
        check("reset_done_valid", SW'(done_valid), SW'(0));
        check("reset_busy", SW'(busy), SW'(0));
        check("reset_state_out", state_out, '0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic selection pattern: A,B,C,D,A into even words.
        start_op('0, SRC_A, 10'b00_11_10_01_00);
        check("busy_in_run", SW'(busy), SW'(1));
        wait_done(1'b0);
        check("t1_word0", SW'(state_out[31:0]), SW'(32'hAAAAAAAA));
        check("t1_word1", SW'(state_out[63:32]), SW'(0));
        check("t1_word6", SW'(state_out[223:192]), SW'(32'hDDDDDDDD));
        check("t1_word8", SW'(state_out[287:256]), SW'(32'hAAAAAAAA));
        finish_op("t1_state");

        // All-ones state, every lane picks word 0.
        start_op({SW{1'b1}}, SRC_A, 10'b0);
        wait_done(1'b0);
        check("t2_word0", SW'(state_out[31:0]), SW'(32'h55555555));
        check("t2_word1", SW'(state_out[63:32]), SW'(32'hFFFFFFFF));
        check("t2_word9", SW'(state_out[319:288]), SW'(32'hFFFFFFFF));
        finish_op("t2_state");

        // Backpressure with an ignored start pulse.
        start_op({10{32'h12345678}}, SRC_A, 10'b11_11_01_10_01);
        wait_done(1'b0);
        held = state_out;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                start_valid = 1'b1; state_in = '1; src_in = '1; sel = '1;
            end
            @(posedge clk); #1;
            start_valid = 1'b0;
            check("bp_done_valid", SW'(done_valid), SW'(1));
            check("bp_state_out", state_out, held);
            check("bp_start_ready", SW'(start_ready), SW'(0));
        end
        finish_op("bp_state");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_no_queue_busy", SW'(busy), SW'(0));
            check("bp_no_queue_done", SW'(done_valid), SW'(0));
        end

        // Inputs change every cycle after accept.
        start_op({10{32'h0F0F1234}}, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 10'b10_01_11_00_10);
        wait_done(1'b1);
        finish_op("scramble_state");

        // Asynchronous reset mid-operation.
        start_op({10{32'hCAFEF00D}}, SRC_A, 10'b01_10_11_00_01);
`ifndef MIX_SEL_PARALLEL_EN
        repeat (3) begin @(posedge clk); #1; end
`endif
        #2 reset = 1'b1;
        #1;
        check("rst_state_out", state_out, '0);
        check("rst_busy", SW'(busy), SW'(0));
        check("rst_done_valid", SW'(done_valid), SW'(0));
        check("rst_start_ready", SW'(start_ready), SW'(1));
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("rst_idle_after_release", SW'(done_valid | busy), SW'(0));
        start_op({10{32'h00FF00FF}}, SRC_A, 10'b00_01_10_11_11);
        wait_done(1'b0);
        finish_op("post_rst_state");

        // A few random operations.
        for (int k = 0; k < 4; k++) begin
            rs = {10{$urandom()}};
            rx = {4{$urandom()}};
            rl = 10'($urandom());
            start_op(rs, rx, rl);
            wait_done(1'b0);
            finish_op("rand_state");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mix_select_seq.md
# mix_select_seq

Sequential, parametrised word-select-and-mix engine for the permutation datapath. It XORs indexed words of a source block (key/nonce/tag material) into strided lanes of a wide cipher state. Each lane's source word is chosen by its own field of a selector vector. By default it processes one lane per clock behind a valid/ready handshake, so it sits between the state register and the round function without a wide parallel mux.

## Interface
Parameters:
- STATE_WIDTH, 320: width of cipher state in bits.
- SRC_WIDTH, 128: width of source block; SRC_WIDTH/WORD_WIDTH must be a power of two ≥ 2.
- WORD_WIDTH, 32: width of one word.
- LANES, 5: number of lanes mixed per operation.
- LANE_STRIDE, 2: distance in words between consecutive lanes; LANES*LANE_STRIDE*WORD_WIDTH ≤ STATE_WIDTH.
- Derived: IDX_W = $clog2(SRC_WIDTH/WORD_WIDTH); LANE_W = $clog2(LANES), minimum 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_valid  in  1  request to mix.
- start_ready  out  1  high only in IDLE.
- state_in  in  STATE_WIDTH  state to mix, captured on accept.
- src_in  in  SRC_WIDTH  source block, captured on accept.
- sel  in  LANES*IDX_W  lane j index is sel[j*IDX_W +: IDX_W], captured on accept.
- done_valid  out  1  result available.
- done_ready  in  1  consumer takes the result.
- state_out  out  STATE_WIDTH  mixed state, registered.
- busy  out  1  high in RUN.

## Operation
- FSM has three states: IDLE, RUN and DONE. Reset enters IDLE and clears lane counter, state_out, src/sel registers, done_valid and busy to 0.
- Transitions:
  - IDLE → RUN when start_valid is high. The edge that accepts the request captures state_in into the state register, src_in and sel, and clears the lane counter.
  - RUN, on each edge: state word [j*LANE_STRIDE] ^= src word [sel_j], where j is the lane counter; then j increments.
  - RUN → DONE on the edge that processes lane LANES-1.
  - DONE → IDLE when done_ready is high.
- State words not addressed by any lane pass through unchanged.
- Inputs are ignored after capture: changes to state_in, src_in or sel during RUN or DONE have no effect.
- start_valid outside IDLE is not accepted, and no request is queued.
- One bubble cycle separates operations, because start_ready is low in DONE even while done_ready is high.
- Two lanes may select the same source word. Each lane is independent, and no collision rules apply.
- state_out shows the working register: it holds partial results during RUN and is valid only while done_valid is high.
- If the `sel` or other input is X or out of range, the result is undefined. All index values within IDX_W are legal.

## Timing
- Accept edge is cycle 0. Lanes are processed on edges 1..LANES. done_valid rises after edge LANES, so default latency is 5 cycles from accept to done_valid.
- done_valid and state_out stay stable until the edge where done_valid && done_ready. done_valid falls on that edge.
- Earliest next accept is the edge after return to IDLE.
- reset asserted mid-RUN or mid-DONE clears everything immediately, asynchronously. The partial result is discarded, and after release the block waits in IDLE for a fresh start.

## Configuration
- MIX_SEL_PARALLEL_EN: when defined, RUN lasts exactly one cycle and all LANES lanes are XORed on that single edge, so latency is 1 cycle. The lane counter is not synthesised.
- When undefined, lanes are processed serially, one per cycle, as described above.
- Handshake, reset behaviour and results are identical in both builds.

## Structure
- Shared package mix_select_pkg holds:
  - typedef enum of FSM states {IDLE, RUN, DONE};
  - the default width constants;
  - a function computing lane base bit offset j*LANE_STRIDE*WORD_WIDTH.
- One combinational sub-module, word_pick, does the indexed extraction of a WORD_WIDTH word from the SRC_WIDTH block. It is instantiated once in serial mode and LANES times in parallel mode.

## Test plan
- Default params, state_in=0, src_in=128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, sel=10'b00_11_10_01_00 → done_valid 5 cycles after accept. Words 0,2,4,6,8 = AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD, AAAAAAAA, and odd words are 0.
- state_in all-ones, same src, sel=0 → even words = 55555555, odd words = FFFFFFFF.
- Backpressure: hold done_ready=0 for 10 cycles → done_valid and state_out stable, start_ready=0, and a start_valid pulse is ignored. Then done_ready=1 → IDLE next edge, and start_ready=1 the cycle after.
- Change state_in, src_in and sel during RUN → result equals the values captured at accept.
- Assert reset after lane 2 → outputs 0 immediately, IDLE after release, and a new op produces a correct result.
- Build with MIX_SEL_PARALLEL_EN and repeat the first test → same result, done_valid 1 cycle after accept.
